// File: rtl/dadda_acc_pkg.sv
// Shared types and widths for the dadda multiply-accumulate stage.
package dadda_acc_pkg;

  localparam int unsigned OPW = 16;
  localparam int unsigned PW  = 32;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  // Frame counter must hold 0..len inclusive.
  function automatic int unsigned cnt_width(input int unsigned len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/dadda_mul.sv
// Combinational 16x16 unsigned multiplier: partial-product rows reduced by a
// 3:2 carry-save tree (16-11-8-6-4-3-2) followed by one carry-propagate add.
module dadda_mul
  import dadda_acc_pkg::*;
(
  output logic [PW-1:0]  p,
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b
);

  function automatic logic [PW-1:0] maj3(input logic [PW-1:0] x,
                                         input logic [PW-1:0] y,
                                         input logic [PW-1:0] z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  logic [PW-1:0] r0 [16];
  logic [PW-1:0] r1 [11];
  logic [PW-1:0] r2 [8];
  logic [PW-1:0] r3 [6];
  logic [PW-1:0] r4 [4];
  logic [PW-1:0] r5 [3];
  logic [PW-1:0] r6 [2];

  for (genvar i = 0; i < 16; i++) begin : g_pp
    assign r0[i] = b[i] ? (PW'(a) << i) : '0;
  end

  for (genvar g = 0; g < 5; g++) begin : g_s1
    assign r1[2*g]   = r0[3*g] ^ r0[3*g+1] ^ r0[3*g+2];
    assign r1[2*g+1] = maj3(r0[3*g], r0[3*g+1], r0[3*g+2]);
  end
  assign r1[10] = r0[15];

  for (genvar g = 0; g < 3; g++) begin : g_s2
    assign r2[2*g]   = r1[3*g] ^ r1[3*g+1] ^ r1[3*g+2];
    assign r2[2*g+1] = maj3(r1[3*g], r1[3*g+1], r1[3*g+2]);
  end
  assign r2[6] = r1[9];
  assign r2[7] = r1[10];

  for (genvar g = 0; g < 2; g++) begin : g_s3
    assign r3[2*g]   = r2[3*g] ^ r2[3*g+1] ^ r2[3*g+2];
    assign r3[2*g+1] = maj3(r2[3*g], r2[3*g+1], r2[3*g+2]);
  end
  assign r3[4] = r2[6];
  assign r3[5] = r2[7];

  for (genvar g = 0; g < 2; g++) begin : g_s4
    assign r4[2*g]   = r3[3*g] ^ r3[3*g+1] ^ r3[3*g+2];
    assign r4[2*g+1] = maj3(r3[3*g], r3[3*g+1], r3[3*g+2]);
  end

  assign r5[0] = r4[0] ^ r4[1] ^ r4[2];
  assign r5[1] = maj3(r4[0], r4[1], r4[2]);
  assign r5[2] = r4[3];

  assign r6[0] = r5[0] ^ r5[1] ^ r5[2];
  assign r6[1] = maj3(r5[0], r5[1], r5[2]);

  // Product fits in PW bits, so the final add never carries out.
  assign p = r6[0] + r6[1];

endmodule

// File: rtl/dadda_mac_acc.sv
// Multiply-accumulate stage: product register, frame accumulator, output handshake.
// Optional build macro DADDA_ACC_SAT_EN makes the accumulator saturate instead of wrap.
module dadda_mac_acc
  import dadda_acc_pkg::*;
#(
  parameter int unsigned LEN = 8,
  parameter int unsigned AW  = 40
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_a,
  input  logic [OPW-1:0] in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [AW-1:0]  out_acc,
  output logic           out_ovf
);

  localparam int unsigned CW = cnt_width(LEN);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   p_q, p_d;
  logic            pv_q, pv_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic            ovf_q, ovf_d;
  logic            ov_q, ov_d;
  logic            run_q;
  logic [PW-1:0]   mul_p;
  logic            accept;
  logic [AW:0]     sum_c;

  dadda_mul u_mul (
    .p (mul_p),
    .a (in_a),
    .b (in_b)
  );

  // run_q keeps in_ready low while reset is asserted.
  assign in_ready = run_q && (state_q == ACC) && (cnt_q < CW'(LEN));
  assign accept   = in_valid && in_ready;
  assign sum_c    = {1'b0, acc_q} + (AW+1)'(p_q);

  // Next-state logic; clr overrides everything else.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    pv_d    = 1'b0;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    ov_d    = ov_q;

    if (accept) begin
      p_d   = mul_p;
      pv_d  = 1'b1;
      cnt_d = cnt_q + CW'(1);
    end

    case (state_q)
      ACC: begin
        if (pv_q) begin
`ifdef DADDA_ACC_SAT_EN
          acc_d = sum_c[AW] ? '1 : sum_c[AW-1:0];
`else
          acc_d = sum_c[AW-1:0];
`endif
          if (sum_c[AW]) ovf_d = 1'b1;
          // cnt can only equal LEN here while the last product is in flight.
          if (cnt_q == CW'(LEN)) begin
            state_d = DONE;
            ov_d    = 1'b1;
          end
        end
      end
      DONE: begin
        if (ov_q && out_ready) begin
          state_d = ACC;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          pv_d    = 1'b0;
          ov_d    = 1'b0;
        end
      end
      default: state_d = ACC;
    endcase

    if (clr) begin
      state_d = ACC;
      acc_d   = '0;
      cnt_d   = '0;
      pv_d    = 1'b0;
      ovf_d   = 1'b0;
      ov_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      cnt_q   <= '0;
      p_q     <= '0;
      pv_q    <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      ov_q    <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      pv_q    <= pv_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      ov_q    <= ov_d;
      run_q   <= 1'b1;
    end
  end

  assign out_valid = ov_q;
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_dadda_mac_acc.sv
// Self-checking bench for dadda_mac_acc: directed frames plus random frames
// against an arithmetic frame-sum model. Honours DADDA_ACC_SAT_EN.
module tb_dadda_mac_acc;

  localparam int unsigned LEN  = 4;
  localparam int unsigned AW   = 40;
  localparam int unsigned LEN2 = 2;
  localparam int unsigned AW2  = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic [15:0]   in_a = '0;
  logic [15:0]   in_b = '0;
  logic          out_ready = 1'b0;

  logic          in_ready, out_valid, out_ovf;
  logic [AW-1:0] out_acc;
  logic          b_in_ready, b_out_valid, b_out_ovf;
  logic [AW2-1:0] b_out_acc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dadda_mac_acc #(.LEN(LEN), .AW(AW)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_ovf(out_ovf)
  );

  dadda_mac_acc #(.LEN(LEN2), .AW(AW2)) u_dut_ovf (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_acc(b_out_acc), .out_ovf(b_out_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Frame result from the true (unbounded) sum of products.
  function automatic logic [63:0] model_acc(input logic [63:0] total, input int aw);
    logic [63:0] mask;
    mask = (64'd1 << aw) - 64'd1;
    if (total <= mask) return total;
`ifdef DADDA_ACC_SAT_EN
    return mask;
`else
    return total & mask;
`endif
  endfunction

  function automatic logic model_ovf(input logic [63:0] total, input int aw);
    return (total >> aw) != 64'd0;
  endfunction

  // Drive one LEN-pair frame into the main instance and check result and handshake.
  task automatic frame_a(input logic [15:0] av[4], input logic [15:0] bv[4],
                         input bit gaps, input int stall, input string tag,
                         output logic [63:0] got);
    logic [63:0] total;
    int n, cyc;
    total = 0; n = 0; cyc = 0;
    out_ready = 1'b0;
    while (n < 4 && cyc < 200) begin
      @(negedge clk);
      in_a = av[n]; in_b = bv[n];
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (in_valid && in_ready) begin
        total += 64'(av[n]) * 64'(bv[n]);
        n++;
      end
      cyc++;
    end
    chk({tag, " accepted"}, 64'(n), 64'd4);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, " valid_early"}, 64'(out_valid), 64'd0);
    chk({tag, " ready_fall"}, 64'(in_ready), 64'd0);
    @(negedge clk);
    chk({tag, " valid"}, 64'(out_valid), 64'd1);
    chk({tag, " acc"}, 64'(out_acc), model_acc(total, AW));
    chk({tag, " ovf"}, 64'(out_ovf), 64'(model_ovf(total, AW)));
    got = 64'(out_acc);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({tag, " hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, " hold_acc"}, 64'(out_acc), got);
      chk({tag, " hold_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " valid_drop"}, 64'(out_valid), 64'd0);
    chk({tag, " ready_rise"}, 64'(in_ready), 64'd1);
    chk({tag, " acc_clear"}, 64'(out_acc), 64'd0);
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    logic [15:0] av[4];
    logic [15:0] bv[4];
    logic [63:0] got, total;
    int n, cyc;
    bit seen;

    // Reset state
    #12;
    chk("rst in_ready", 64'(in_ready), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_acc", 64'(out_acc), 64'd0);
    chk("rst out_ovf", 64'(out_ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst in_ready", 64'(in_ready), 64'd1);

    // Basic frame of max operands
    av = '{16'hffff, 16'hffff, 16'hffff, 16'hffff};
    bv = '{16'hffff, 16'hffff, 16'hffff, 16'hffff};
    frame_a(av, bv, 1'b0, 0, "basic", got);
    chk("basic literal", got, 64'h3_FFF8_0004);

    // Mixed operands
    av = '{16'h7fff, 16'h00ff, 16'h0170, 16'h0002};
    bv = '{16'h0002, 16'h00ff, 16'h0180, 16'h0000};
    frame_a(av, bv, 1'b0, 0, "mixed", got);
    chk("mixed literal", got, 64'h425FF);

    // Backpressure for 5 cycles
    av = '{16'h1234, 16'h0001, 16'h8000, 16'h00aa};
    bv = '{16'h5678, 16'hffff, 16'h8000, 16'h0055};
    frame_a(av, bv, 1'b0, 5, "bp", got);

    // Abort after 2 pairs; a pair offered together with clr is dropped
    n = 0; cyc = 0;
    while (n < 2 && cyc < 50) begin
      @(negedge clk);
      in_a = 16'hffff; in_b = 16'hffff; in_valid = 1'b1;
      if (in_ready) n++;
      cyc++;
    end
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    chk("abort acc", 64'(out_acc), 64'd0);
    av = '{16'h00ff, 16'h00ff, 16'h00ff, 16'h00ff};
    bv = '{16'h00ff, 16'h00ff, 16'h00ff, 16'h00ff};
    frame_a(av, bv, 1'b0, 0, "abort", got);
    chk("abort literal", got, 64'h3F804);

    // Overflow on the LEN=2, AW=32 instance
    clr_pulse();
    total = 0; n = 0; cyc = 0;
    while (n < 2 && cyc < 50) begin
      @(negedge clk);
      in_a = 16'hffff; in_b = 16'hffff; in_valid = 1'b1;
      if (b_in_ready) begin
        total += 64'(16'hffff) * 64'(16'hffff);
        n++;
      end
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("ovf valid", 64'(b_out_valid), 64'd1);
    chk("ovf acc", 64'(b_out_acc), model_acc(total, AW2));
`ifdef DADDA_ACC_SAT_EN
    chk("ovf literal", 64'(b_out_acc), 64'hFFFF_FFFF);
`else
    chk("ovf literal", 64'(b_out_acc), 64'hFFFC_0002);
`endif
    chk("ovf flag", 64'(b_out_ovf), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("ovf flag_clear", 64'(b_out_ovf), 64'd0);
    clr_pulse();

    // Random frames with gaps and stalls
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 4; i++) begin
        av[i] = 16'($urandom);
        bv[i] = 16'($urandom);
      end
      frame_a(av, bv, 1'b1, int'($urandom_range(0, 3)), "rand", got);
    end

    // Asynchronous reset mid-frame with a product in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_a = 16'hffff; in_b = 16'h0f0f; in_valid = 1'b1;
    end
    @(posedge clk);
    #2;
    chk("pre_rst acc_nonzero", 64'(out_acc != '0), 64'd1);
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("midrst out_acc", 64'(out_acc), 64'd0);
    chk("midrst out_valid", 64'(out_valid), 64'd0);
    chk("midrst in_ready", 64'(in_ready), 64'd0);
    chk("midrst out_ovf", 64'(out_ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("midrst no_output", 64'(seen), 64'd0);
    chk("midrst ready", 64'(in_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
